alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/alu_arbiter_rr_pick.sv | 43 ++++
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcode constants, FSM states and command struct for the ALU arbiter.
// Pure declarations: no latency and no backpressure of its own.
package alu_arb_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } alu_cmd_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL};
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after ptr, wrapping modulo NREQ.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    localparam int SW = IDW + 2;
    localparam logic [SW-1:0] NREQ_W = SW'(NREQ);

    logic [SW-1:0]   start;
    logic [SW-1:0]   off;
    logic [SW-1:0]   sum;
    logic [NREQ-1:0] rot;

    // Rotating a doubled copy puts requester ptr+1 at bit 0, so a plain
    // lowest-set-bit search gives the round-robin winner for any NREQ.
    always_comb begin
        start = {2'b00, ptr} + SW'(1);
        rot   = NREQ'({req, req} >> start);
        off   = '0;
        found = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off   = SW'(j);
                found = 1'b1;
            end
        end
        sum   = start + off;
        idx   = IDW'((sum >= NREQ_W) ? (sum - NREQ_W) : sum);
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = found && (idx == IDW'(i));
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one single-cycle ALU among NREQ requesters, one op in flight; result at T+2.
// Holds the response until rsp_ready; ALU_ARB_OPCHECK_EN answers illegal opcodes at T+1 with rsp_err.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [2:0]        alu_op,
    input  logic [31:0]       alu_out,
    input  logic              alu_zero
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    alu_cmd_t        cmd;
    alu_cmd_t        req_cmd [NREQ];
    alu_cmd_t        sel;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  pick;
    logic            pick_found;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_cmd[i] = {req_a[32*i +: 32], req_b[32*i +: 32], req_op[3*i +: 3]};
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (pick),
        .found (pick_found)
    );

    assign sel       = req_cmd[pick];
    assign req_ready = (state == IDLE) ? grant : '0;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign alu_a     = cmd.a;
    assign alu_b     = cmd.b;
    assign alu_op    = cmd.op;

`ifdef ALU_ARB_OPCHECK_EN
    logic err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= IDW'(NREQ - 1);
            cmd      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        ptr    <= pick;
                        rsp_id <= pick;
`ifdef ALU_ARB_OPCHECK_EN
                        // Illegal ops never reach the ALU, so its inputs stay untouched.
                        if (!op_legal(sel.op)) begin
                            err_q    <= 1'b1;
                            rsp_data <= '0;
                            rsp_zero <= 1'b0;
                            state    <= RESP;
                        end else begin
                            err_q <= 1'b0;
                            cmd   <= sel;
                            state <= EXEC;
                        end
`else
                        cmd   <= sel;
                        state <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    rsp_zero <= alu_zero;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*3-1:0]  req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_data;
    logic               rsp_zero;
    logic               rsp_err;
    logic               busy;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [2:0]         alu_op;
    logic [31:0]        alu_out;
    logic               alu_zero;

    logic [31:0] ra  [NREQ];
    logic [31:0] rb  [NREQ];
    logic [2:0]  rop [NREQ];

    int n_cmp = 0;
    int n_err = 0;
    int exp_last;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[32*g +: 32] = ra[g];
        assign req_b[32*g +: 32] = rb[g];
        assign req_op[3*g +: 3]  = rop[g];
    end

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero)
    );

    // Behavioural ALU: {zero, result}; illegal opcodes give 0 with zero set.
    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b101:  r = (a < b) ? 32'd1 : 32'd0;
            3'b110:  r = b << a;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    always_comb {alu_zero, alu_out} = ref_alu(alu_a, alu_b, alu_op);

    function automatic int rr_next(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_last = NREQ - 1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if (req_ready !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: ready=%b busy=%b valid=%b, want all 0", req_ready, busy, rsp_valid);
        end
        n_cmp++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'b000) begin
            n_err++; $display("FAIL reset_alu: a=%h b=%h op=%b, want 0", alu_a, alu_b, alu_op);
        end
        n_cmp++;
        if (rsp_data !== 32'd0 || rsp_zero !== 1'b0 || rsp_id !== '0 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL reset_rsp: data=%h zero=%b id=%0d err=%b, want 0", rsp_data, rsp_zero, rsp_id, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = NREQ - 1;
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL reset_first_grant: got %b want 01", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        ra[0] = 32'd5; rb[0] = 32'd3; rop[0] = 3'b000;
        req_valid = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL single_ready: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 3'b000) begin
            n_err++; $display("FAIL single_exec: busy=%b valid=%b a=%h b=%h op=%b want 1 0 5 3 000", busy, rsp_valid, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd8 || rsp_zero !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL single_rsp: valid=%b data=%h zero=%b id=%0d err=%b want 1 8 0 0 0", rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_done: valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
        exp_last = 0;
    endtask

    task automatic test_alternate();
        int want;
        do_reset();
        ra[1] = 32'd7;     rb[1] = 32'd7;     rop[1] = 3'b001;
        ra[0] = 32'h0000_00F0; rb[0] = 32'h0000_000F; rop[0] = 3'b011;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            want = k % 2;
            #1;
            n_cmp++;
            if (req_ready !== onehot(want)) begin
                n_err++; $display("FAIL alt_grant[%0d]: got %b want %b", k, req_ready, onehot(want));
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(want) ||
                rsp_data !== ((want == 0) ? 32'h0000_00FF : 32'd0) || rsp_zero !== (want == 1)) begin
                n_err++; $display("FAIL alt_rsp[%0d]: valid=%b id=%0d data=%h zero=%b want id %0d", k, rsp_valid, rsp_id, rsp_data, rsp_zero, want);
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        exp_last = 1;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        ra[0] = 32'd10; rb[0] = 32'd20; rop[0] = 3'b000;
        req_valid = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL bp_ready: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        for (int h = 0; h < 5; h++) begin
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd30 || rsp_id !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%0d want 1 1e 0", h, rsp_valid, rsp_data, rsp_id);
            end
            n_cmp++;
            if (req_ready !== 2'b00 || busy !== 1'b1) begin
                n_err++; $display("FAIL bp_block[%0d]: ready=%b busy=%b want 00 1", h, req_ready, busy);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL bp_next_grant: got %b want 10", req_ready);
        end
        req_valid = '0;
        exp_last = 0;
    endtask

    task automatic test_ops();
        int          tr [5] = '{1, 0, 1, 0, 1};
        logic [31:0] ta [5] = '{32'd2, 32'd3, 32'd1, 32'd3, 32'h0000_0F0F};
        logic [31:0] tb [5] = '{32'd3, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h0000_FF00};
        logic [2:0]  to [5] = '{3'b110, 3'b101, 3'b101, 3'b001, 3'b010};
        logic [31:0] td [5] = '{32'd12, 32'd0, 32'd1, 32'hFFFF_FFFE, 32'h0000_0F00};
        logic        tz [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            ra[tr[t]] = ta[t]; rb[tr[t]] = tb[t]; rop[tr[t]] = to[t];
            req_valid = onehot(tr[t]);
            #1;
            n_cmp++;
            if (req_ready !== onehot(tr[t])) begin
                n_err++; $display("FAIL ops_ready[%0d]: got %b want %b", t, req_ready, onehot(tr[t]));
            end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== td[t] || rsp_zero !== tz[t] || rsp_id !== IDW'(tr[t])) begin
                n_err++; $display("FAIL ops_rsp[%0d]: valid=%b data=%h zero=%b id=%0d want 1 %h %b %0d",
                                  t, rsp_valid, rsp_data, rsp_zero, rsp_id, td[t], tz[t], tr[t]);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        exp_last = 1;
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        ra[0] = 32'd1; rb[0] = 32'd1; rop[0] = 3'b001;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || alu_op !== 3'b001) begin
            n_err++; $display("FAIL rst_exec_pre: busy=%b op=%b want 1 001", busy, alu_op);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_op !== 3'b000 || alu_a !== 32'd0) begin
            n_err++; $display("FAIL rst_exec_async: valid=%b busy=%b op=%b a=%h want 0 0 000 0", rsp_valid, busy, alu_op, alu_a);
        end
        #1 rst_n = 1'b1;
        exp_last = NREQ - 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_exec_no_rsp[%0d]: valid=%b want 0", c, rsp_valid);
            end
        end
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL rst_exec_grant: got %b want 01", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_illegal();
        logic [2:0] bad [2] = '{3'b100, 3'b111};
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            ra[1] = 32'd9; rb[1] = 32'd6; rop[1] = 3'b011;
            req_valid = 2'b10;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd15) begin
                n_err++; $display("FAIL ill_setup[%0d]: valid=%b data=%h want 1 f", t, rsp_valid, rsp_data);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            ra[0] = 32'h55; rb[0] = 32'h66; rop[0] = bad[t];
            req_valid = 2'b01;
            #1;
            n_cmp++;
            if (req_ready !== 2'b01) begin
                n_err++; $display("FAIL ill_ready[%0d]: got %b want 01", t, req_ready);
            end
            @(negedge clk);
            req_valid = '0;
            #1;
`ifdef ALU_ARB_OPCHECK_EN
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
                n_err++; $display("FAIL ill_rsp[%0d]: valid=%b err=%b data=%h zero=%b id=%0d want 1 1 0 0 0", t, rsp_valid, rsp_err, rsp_data, rsp_zero, rsp_id);
            end
            n_cmp++;
            if (alu_op !== 3'b011 || alu_a !== 32'd9) begin
                n_err++; $display("FAIL ill_alu_held[%0d]: op=%b a=%h want 011 9", t, alu_op, alu_a);
            end
`else
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL ill_early[%0d]: valid=%b want 0", t, rsp_valid);
            end
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b0) begin
                n_err++; $display("FAIL ill_rsp[%0d]: valid=%b err=%b data=%h zero=%b id=%0d want 1 0 0 1 0", t, rsp_valid, rsp_err, rsp_data, rsp_zero, rsp_id);
            end
`endif
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL ill_done[%0d]: valid=%b want 0", t, rsp_valid);
            end
        end
        exp_last = 0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v;
        logic [32:0]     r;
        logic            exp_err;
        int              g, lat, cnt;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            v = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                ra[i]  = $urandom;
                rb[i]  = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
                rop[i] = 3'($urandom_range(0, 7));
                if (rop[i] == 3'b110) ra[i] = $urandom_range(0, 40);
            end
            req_valid = v;
            #1;
            g = rr_next(exp_last, v);
            n_cmp++;
            if (req_ready !== onehot(g)) begin
                n_err++; $display("FAIL rand_grant[%0d]: valid=%b got %b want %b", it, v, req_ready, onehot(g));
            end
            if (g >= 0) begin
                exp_last = g;
                r = ref_alu(ra[g], rb[g], rop[g]);
                exp_err = 1'b0;
                lat = 2;
`ifdef ALU_ARB_OPCHECK_EN
                if (rop[g] == 3'b100 || rop[g] == 3'b111) begin
                    r = 33'd0;
                    exp_err = 1'b1;
                    lat = 1;
                end
`endif
                @(negedge clk);
                req_valid = '0;
                cnt = 1;
                while (!rsp_valid && cnt < 6) begin
                    @(negedge clk);
                    cnt++;
                end
                n_cmp++;
                if (cnt != lat) begin
                    n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, cnt, lat);
                end
                if (rsp_valid) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    #1;
                    n_cmp++;
                    if (rsp_data !== r[31:0] || rsp_zero !== r[32] || rsp_err !== exp_err || rsp_id !== IDW'(g)) begin
                        n_err++; $display("FAIL rand_rsp[%0d]: data=%h zero=%b err=%b id=%0d want %h %b %b %0d",
                                          it, rsp_data, rsp_zero, rsp_err, rsp_id, r[31:0], r[32], exp_err, g);
                    end
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                    n_cmp++;
                    if (rsp_valid !== 1'b0) begin
                        n_err++; $display("FAIL rand_done[%0d]: valid=%b want 0", it, rsp_valid);
                    end
                end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0; rb[i] = '0; rop[i] = '0;
        end
        exp_last = NREQ - 1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_ops();
        test_reset_mid_exec();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
